// File: rtl/mem_responder.sv
// mem_responder: word-addressed synchronous RAM that serves the datapath's Read/Write requests.
// Each request is latched in IDLE, waits LATENCY cycles, performs a single-edge access, and
// then holds Done until the requester drops the request (four-phase handshake).
// Assumes 2**$clog2(DEPTH) <= 2**ADDR_W, i.e. DEPTH fits in the address range.

module mem_responder #(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    output logic [31:0]       Mdatain,
    output logic              Done,
    output logic              busy,
    output logic              err
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              in_range;
    logic              mem_we;
    logic [IdxW-1:0]   idx;

    // Contents start at zero and are deliberately untouched by clr.
    logic [31:0] mem [DEPTH] = '{default: '0};

    assign in_range = 32'(addr_q) < DEPTH;
    assign idx      = addr_q[IdxW-1:0];

    // Next-state: request capture, wait countdown, access, handshake release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Read ^ Write) begin
                    addr_d  = address;
                    we_d    = Write;
                    wdata_d = data_in;
                    cnt_d   = 4'(LATENCY);
                    err_d   = 1'b0;
                    state_d = StWait;
                end else if (Read && Write) begin
                    err_d = 1'b1;
                end
            end
            StWait: begin
                // Requester inputs are ignored here; only the latched copies matter.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StDone;
                    if (!in_range) begin
                        err_d = 1'b1;
                        if (!we_q) rdata_d = '0;
                    end else if (we_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem[idx];
                    end
                end
            end
            StDone: begin
                if (!Read && !Write) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and data registers; clr wins over everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory write port; a write landing on a clr edge is discarded.
    always_ff @(posedge clk) begin
        if (mem_we && !clr) mem[idx] <= wdata_q;
    end

    assign Mdatain = rdata_q;
    assign Done    = (state_q == StDone);
    assign busy    = (state_q != StIdle);
    assign err     = err_q;

endmodule
